aud_recorder: RTL and testbench

- Record-side counterpart to the playback DSP. Accepts 16-bit audio samples from the ADC/I2S deserializer as single-cycle strobes and writes them to sequential SRAM addresses starting at 0.
- Start/pause/stop control matches playback, so a recording can be played back from address 0.
- Reports the live recorded length and a full flag for the top level and the spectral-flux front end.

---
 rtl/aud_recorder.sv | 109 ++++++++++
 tb/tb_aud_recorder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/aud_recorder.sv
// Record-side sample sink: writes strobed audio samples to sequential SRAM
// addresses from 0 with start/pause/stop control and a full stop at MAX_ADDR.
module aud_recorder #(
  parameter int          ADDR_W   = 20,
  parameter int          DATA_W   = 16,
  parameter int unsigned MAX_ADDR = (2**ADDR_W) - 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_pause,
  input  logic                     i_stop,
  input  logic                     i_sample_valid,
  input  logic signed [DATA_W-1:0] i_sample_data,
  output logic [ADDR_W-1:0]        o_sram_addr,
  output logic signed [DATA_W-1:0] o_sram_data,
  output logic                     o_sram_we,
  output logic [ADDR_W:0]          o_rec_len,
  output logic                     o_full,
  output logic [2:0]               o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REC   = 3'd1,
    S_PAUSE = 3'd2,
    S_FULL  = 3'd3
  } state_t;

  localparam logic [ADDR_W:0] LAST_WP = (ADDR_W+1)'(MAX_ADDR);

  state_t                     state_q, state_d;
  logic [ADDR_W:0]            wp_q, wp_d;
  logic                       we_q, we_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic signed [DATA_W-1:0]   data_q, data_d;

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_REC;
          wp_d    = '0;
        end
      end
      S_REC: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end else begin
          if (i_sample_valid) begin
            we_d   = 1'b1;
            addr_d = wp_q[ADDR_W-1:0];
            data_d = i_sample_data;
            wp_d   = wp_q + 1'b1;
          end
          // Filling the last address wins over a same-cycle pause.
          if (i_sample_valid && (wp_q == LAST_WP)) begin
            state_d = S_FULL;
          end else if (i_pause) begin
            state_d = S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end else if (i_start) begin
          state_d = S_REC;
        end
      end
      S_FULL: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register stage: write strobe lands one cycle after acceptance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      wp_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign o_sram_addr = addr_q;
  assign o_sram_data = data_q;
  assign o_sram_we   = we_q;
  assign o_rec_len   = wp_q;
  assign o_full      = (state_q == S_FULL);
  assign o_state     = state_q;

endmodule

// File: tb/tb_aud_recorder.sv
// Bench for aud_recorder with a small address space so the full condition is reachable.
module tb_aud_recorder;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;

  localparam int M_IDLE  = 0;
  localparam int M_REC   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_FULL  = 3;

  logic              clk = 1'b0;
  logic              rst, start, pause, stop, valid;
  logic [DATA_W-1:0] sdata;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_data;
  logic              sram_we;
  logic [ADDR_W:0]   rec_len;
  logic              full;
  logic [2:0]        state;

  int compared = 0;
  int mismatched = 0;

  int          m_mode = M_IDLE;
  int          m_len  = 0;
  logic        m_we   = 1'b0;
  int          m_addr = 0;
  logic [15:0] m_data = '0;

  aud_recorder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_sample_valid(valid), .i_sample_data(sdata),
    .o_sram_addr(sram_addr), .o_sram_data(sram_data), .o_sram_we(sram_we),
    .o_rec_len(rec_len), .o_full(full), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one clock edge given the inputs presented.
  task automatic model_edge();
    m_we = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_len = 0; m_addr = 0; m_data = '0;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin m_mode = M_REC; m_len = 0; end
        M_REC: begin
          if (stop) m_mode = M_IDLE;
          else begin
            if (valid) begin
              m_we = 1'b1; m_addr = m_len; m_data = sdata; m_len++;
            end
            if (valid && m_len == DEPTH) m_mode = M_FULL;
            else if (pause) m_mode = M_PAUSE;
          end
        end
        M_PAUSE: if (stop) m_mode = M_IDLE; else if (start) m_mode = M_REC;
        M_FULL: if (stop) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic cyc(input logic r, input logic st, input logic pa, input logic sp,
                     input logic v, input logic [15:0] d);
    rst = r; start = st; pause = pa; stop = sp; valid = v; sdata = d;
    @(posedge clk);
    model_edge();
    #1;
    chk("we", sram_we, m_we);
    chk("addr", sram_addr, m_addr);
    chk("data", sram_data, m_data);
    chk("rec_len", rec_len, m_len);
    chk("full", full, m_mode == M_FULL);
    chk("state", state, m_mode);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic smp(input logic [15:0] d);
    cyc(0, 0, 0, 0, 1, d);
  endtask

  logic [15:0] basic_d [4] = '{16'h0001, 16'h8000, 16'h7FFF, 16'hFFFE};

  initial begin
    rst = 1; start = 0; pause = 0; stop = 0; valid = 0; sdata = '0;
    cyc(1, 0, 0, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 0, 16'h0);
    chk("reset_state", state, 3'd0);
    chk("reset_len", rec_len, 5'd0);

    // Basic record
    cyc(0, 1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      smp(basic_d[i]);
      chk("basic_addr", sram_addr, i);
      chk("basic_data", sram_data, basic_d[i]);
      nop(2);
    end
    cyc(0, 0, 0, 1, 0, 16'h0);
    nop(3);
    chk("basic_len", rec_len, 5'd4);
    chk("basic_idle", state, 3'd0);

    // Pause/resume
    cyc(0, 1, 0, 0, 0, 16'h0);
    smp(16'h1111); smp(16'h2222);
    cyc(0, 0, 1, 0, 1, 16'h3333);
    chk("pause_wr_addr", sram_addr, 4'd2);
    chk("pause_state", state, 3'd2);
    smp(16'h4444);
    chk("pause_no_we", sram_we, 1'b0);
    smp(16'h5555);
    cyc(0, 1, 0, 0, 0, 16'h0);
    smp(16'h6666);
    chk("resume_addr", sram_addr, 4'd3);
    chk("resume_data", sram_data, 16'h6666);
    chk("resume_len", rec_len, 5'd4);

    // Stop collision
    cyc(0, 0, 0, 1, 1, 16'h1234);
    chk("coll_we", sram_we, 1'b0);
    chk("coll_len", rec_len, 5'd4);
    chk("coll_state", state, 3'd0);
    nop(1);

    // Full
    cyc(0, 1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 17; i++) smp(16'hA000 + 16'(i));
    chk("full_flag", full, 1'b1);
    chk("full_len", rec_len, 5'd16);
    cyc(0, 1, 0, 0, 1, 16'hBEEF);
    cyc(0, 0, 1, 0, 1, 16'hBEEF);
    chk("full_hold", state, 3'd3);
    cyc(0, 0, 0, 1, 0, 16'h0);
    chk("full_exit", full, 1'b0);
    chk("full_len_hold", rec_len, 5'd16);

    // Restart
    cyc(0, 1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 5; i++) smp(16'hC000 + 16'(i));
    cyc(0, 0, 0, 1, 0, 16'h0);
    chk("restart_prev_len", rec_len, 5'd5);
    cyc(0, 1, 0, 0, 0, 16'h0);
    chk("restart_len0", rec_len, 5'd0);
    smp(16'hD00D);
    chk("restart_addr0", sram_addr, 4'd0);
    chk("restart_we", sram_we, 1'b1);

    // Reset mid-operation
    cyc(1, 0, 0, 0, 1, 16'hEEEE);
    chk("rst_mid_we", sram_we, 1'b0);
    chk("rst_mid_data", sram_data, 16'h0);
    chk("rst_mid_state", state, 3'd0);

    // Randomized control and sample traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(99) == 0), ($urandom_range(9) == 0), ($urandom_range(9) == 0),
          ($urandom_range(24) == 0), ($urandom_range(1) == 1), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
